// File: rtl/rom_line_cache.sv
// Direct-mapped read-only line cache between a CPU program-ROM port and the SDRAM ROM channel.
// Define ROM_LINE_CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
`timescale 1ns/1ps
module rom_line_cache #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int SET_W  = 8,
    parameter int LINE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cache_req,
    input  logic [ADDR_W-1:0] cache_addr,
    output logic              cache_valid,
    output logic [DATA_W-1:0] cache_data,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_valid
`ifdef ROM_LINE_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int IDX_W = SET_W + LINE_W;
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int OFF_W = (LINE_W > 0) ? LINE_W : 1;
    localparam int LINES = 1 << SET_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'((1 << LINE_W) - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, HOLD} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]      req_addr;
    logic [TAG_W-1:0]       req_tag;
    logic [SET_W-1:0]       req_set;
    logic [OFF_W-1:0]       req_off;
    logic [OFF_W-1:0]       beat;
    logic                   flush_seen;
    logic                   abandoned;
    logic [LINES-1:0]       valid;
    logic [TAG_W-1:0]       tag_ram [LINES];
    logic [DATA_W-1:0]      data_ram [DEPTH];
    logic [TAG_W-1:0]       tag_rd;
    logic [DATA_W-1:0]      data_rd;
    logic                   hit;
    logic                   fill_beat;
    logic                   fill_last;
    logic [SET_W+OFF_W-1:0] wr_cat;
    logic [IDX_W-1:0]       wr_idx;

    assign req_tag   = req_addr[ADDR_W-1:IDX_W];
    assign req_set   = req_addr[IDX_W-1:LINE_W];
    assign req_off   = req_addr[OFF_W-1:0] & LAST;
    // With single-word lines the padding counter bit is shifted out of the RAM index.
    assign wr_cat    = {req_set, beat};
    assign wr_idx    = IDX_W'(wr_cat >> (OFF_W - LINE_W));
    assign hit       = valid[req_set] && (tag_rd == req_tag);
    assign fill_beat = (state == FILL) && rom_valid && !reset;
    assign fill_last = fill_beat && (beat == LAST);

    always_ff @(posedge clk) begin
        tag_rd <= tag_ram[cache_addr[IDX_W-1:LINE_W]];
        if (fill_last)
            tag_ram[req_set] <= req_tag;
    end

    always_ff @(posedge clk) begin
        data_rd <= data_ram[cache_addr[IDX_W-1:0]];
        if (fill_beat)
            data_ram[wr_idx] <= rom_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cache_req) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = hit ? HOLD : FILL;
            FILL:    if (fill_last) state_nxt = (cache_req && !abandoned) ? HOLD : IDLE;
            HOLD:    if (!cache_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cache_valid = (state == HOLD);
        rom_req     = (state == FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= '0;
            beat       <= '0;
            flush_seen <= 1'b0;
            abandoned  <= 1'b0;
            rom_addr   <= '0;
        end else begin
            if (state == LOOKUP && !hit) begin
                beat       <= '0;
                flush_seen <= 1'b0;
                abandoned  <= 1'b0;
                rom_addr   <= (req_addr >> LINE_W) << LINE_W;
            end
            if (fill_beat)
                beat <= (beat == LAST) ? '0 : beat + 1'b1;
            if (state == FILL && flush)
                flush_seen <= 1'b1;
            // A requester that lets go mid-burst must not see this fill's data later.
            if (state == FILL && !cache_req)
                abandoned <= 1'b1;
            if (flush)
                valid <= '0;
            else if (fill_last && !flush_seen)
                valid[req_set] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cache_req)
            req_addr <= cache_addr;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cache_data <= '0;
        else if (state == LOOKUP && hit)
            cache_data <= data_rd;
        else if (fill_beat && beat == req_off)
            cache_data <= rom_data;
    end

`ifdef ROM_LINE_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (!hit && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rom_line_cache.sv
// Self-checking bench for rom_line_cache: directed scenarios plus randomized reads against a line-level model.
`timescale 1ns/1ps
module tb_rom_line_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        cache_req;
    logic [22:0] cache_addr;
    logic        cache_valid;
    logic [15:0] cache_data;
    logic        rom_req;
    logic [22:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_valid;
`ifdef ROM_LINE_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;

    bit          mvalid [256];
    logic [12:0] mtag   [256];
    int          mhits;
    int          mmiss;

    always #5 clk = ~clk;

    rom_line_cache dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .cache_req  (cache_req),
        .cache_addr (cache_addr),
        .cache_valid(cache_valid),
        .cache_data (cache_data),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_valid  (rom_valid)
`ifdef ROM_LINE_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // ROM contents: line 0x104 holds A000..A003, everything else a scrambled pattern.
    function automatic logic [15:0] mem(input logic [22:0] a);
        logic [22:0] t;
        if (a[22:2] == 21'h41)
            return 16'hA000 + 16'(a[1:0]);
        t = (a * 23'd40503) ^ 23'h05A5A;
        return t[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        mhits = 0;
        mmiss = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cache_req = 1'b0; flush = 1'b0; rom_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
    endtask

    // One complete read transaction; the model decides hit or miss and the expected data.
    task automatic access(input logic [22:0] a, input int flush_beat, input int drop_after,
                          input int rst_after, input int gap);
        logic [7:0]  s;
        logic [12:0] t;
        logic [22:0] line;
        logic        exp_hit;
        logic        flushed;
        logic        dropped;
        s = a[9:2];
        t = a[22:10];
        line = {a[22:2], 2'b00};
        exp_hit = mvalid[s] && (mtag[s] == t);
        flushed = 1'b0;
        dropped = 1'b0;
        cache_addr = a;
        cache_req = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (cache_valid !== 1'b0 || rom_req !== 1'b0) begin
            fails++;
            $display("FAIL lookup_quiet a=%h got valid=%b rom_req=%b want 0/0", a, cache_valid, rom_req);
        end
        @(posedge clk); #1;
        if (exp_hit) begin
            mhits++;
            tests++;
            if (cache_valid !== 1'b1 || cache_data !== mem(a) || rom_req !== 1'b0) begin
                fails++;
                $display("FAIL hit a=%h got valid=%b data=%h rom_req=%b want 1/%h/0",
                         a, cache_valid, cache_data, rom_req, mem(a));
            end
            @(posedge clk); #1;
            tests++;
            if (cache_valid !== 1'b1 || cache_data !== mem(a)) begin
                fails++;
                $display("FAIL hit_hold a=%h got valid=%b data=%h want 1/%h", a, cache_valid, cache_data, mem(a));
            end
            cache_req = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (cache_valid !== 1'b0) begin
                fails++;
                $display("FAIL hit_release a=%h got valid=%b want 0", a, cache_valid);
            end
            return;
        end
        mmiss++;
        tests++;
        if (rom_req !== 1'b1 || rom_addr !== line || cache_valid !== 1'b0) begin
            fails++;
            $display("FAIL miss_req a=%h got rom_req=%b rom_addr=%h valid=%b want 1/%h/0",
                     a, rom_req, rom_addr, cache_valid, line);
        end
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                tests++;
                if (rom_req !== 1'b1 || cache_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL fill_wait a=%h got rom_req=%b valid=%b want 1/0", a, rom_req, cache_valid);
                end
            end
            rom_data = mem(line + 23'(b));
            rom_valid = 1'b1;
            flush = (flush_beat == b + 1);
            if (flush) flushed = 1'b1;
            @(posedge clk); #1;
            rom_valid = 1'b0;
            flush = 1'b0;
            rom_data = 16'($urandom);
            if (drop_after == b + 1) begin
                cache_req = 1'b0;
                dropped = 1'b1;
            end
            if (rst_after == b + 1) begin
                reset = 1'b1;
                cache_req = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                tests++;
                if (rom_req !== 1'b0 || cache_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_midfill a=%h got rom_req=%b valid=%b want 0/0", a, rom_req, cache_valid);
                end
                model_reset();
                @(posedge clk); #1;
                return;
            end
            if (b < 3) begin
                tests++;
                if (rom_req !== 1'b1 || cache_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL fill_beat%0d a=%h got rom_req=%b valid=%b want 1/0", b, a, rom_req, cache_valid);
                end
            end
        end
        if (flushed) begin
            for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        end else begin
            mvalid[s] = 1'b1;
            mtag[s] = t;
        end
        if (!dropped) begin
            tests++;
            if (cache_valid !== 1'b1 || cache_data !== mem(a) || rom_req !== 1'b0) begin
                fails++;
                $display("FAIL miss_data a=%h got valid=%b data=%h rom_req=%b want 1/%h/0",
                         a, cache_valid, cache_data, rom_req, mem(a));
            end
            @(posedge clk); #1;
            cache_req = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (cache_valid !== 1'b0) begin
                fails++;
                $display("FAIL miss_release a=%h got valid=%b want 0", a, cache_valid);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (cache_valid !== 1'b0 || rom_req !== 1'b0) begin
                    fails++;
                    $display("FAIL abandoned a=%h got valid=%b rom_req=%b want 0/0", a, cache_valid, rom_req);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; cache_req = 1'b0; cache_addr = '0; rom_data = '0; rom_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (cache_valid !== 1'b0 || rom_req !== 1'b0 || rom_addr !== 23'd0 || cache_data !== 16'd0) begin
            fails++;
            $display("FAIL reset_state got valid=%b rom_req=%b rom_addr=%h data=%h want all 0",
                     cache_valid, rom_req, rom_addr, cache_data);
        end
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss_and_hits();
        access(23'h000105, 0, 0, 0, 0);
        access(23'h000104, 0, 0, 0, 1);
        access(23'h000106, 0, 0, 0, 0);
        access(23'h000107, 0, 0, 0, 0);
    endtask

    task automatic test_conflict();
        access(23'h000504, 0, 0, 0, 0);
        access(23'h000104, 0, 0, 0, 2);
        access(23'h000105, 0, 0, 0, 0);
    endtask

    task automatic test_flush_fill();
        do_reset();
        access(23'h000200, 2, 0, 0, 0);
        access(23'h000200, 0, 0, 0, 0);
`ifdef ROM_LINE_CACHE_STATS_EN
        tests++;
        if (hit_count !== 32'(mhits) || miss_count !== 32'(mmiss) || mmiss != 2 || mhits != 0) begin
            fails++;
            $display("FAIL stats_flush got hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, mhits, mmiss);
        end
`endif
    endtask

    task automatic test_flush_idle();
        access(23'h000201, 0, 0, 0, 0);
        flush_pulse();
        access(23'h000203, 0, 0, 0, 0);
    endtask

    task automatic test_abandoned();
        access(23'h000302, 0, 1, 0, 1);
        access(23'h000301, 0, 0, 0, 0);
    endtask

    task automatic test_reset_midfill();
        access(23'h000401, 0, 0, 2, 0);
        access(23'h000401, 0, 0, 0, 0);
    endtask

    task automatic test_stray_rom_valid();
        for (int i = 0; i < 3; i++) begin
            rom_valid = 1'b1;
            rom_data = 16'hBEEF;
            @(posedge clk); #1;
            tests++;
            if (cache_valid !== 1'b0 || rom_req !== 1'b0) begin
                fails++;
                $display("FAIL stray_beat got valid=%b rom_req=%b want 0/0", cache_valid, rom_req);
            end
        end
        rom_valid = 1'b0;
        access(23'h000402, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int t, s, o, fb, dr;
        for (int n = 0; n < 80; n++) begin
            t = $urandom_range(0, 2);
            s = $urandom_range(0, 3);
            o = $urandom_range(0, 3);
            fb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            dr = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 15) == 0) flush_pulse();
            access({13'(t), 8'(s), 2'(o)}, fb, dr, 0, $urandom_range(0, 2));
        end
`ifdef ROM_LINE_CACHE_STATS_EN
        tests++;
        if (hit_count !== 32'(mhits) || miss_count !== 32'(mmiss)) begin
            fails++;
            $display("FAIL stats_random got hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, mhits, mmiss);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hits();
        test_conflict();
        test_flush_fill();
        test_flush_idle();
        test_abandoned();
        test_reset_midfill();
        test_stray_rom_valid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rom_line_cache.md
Name: rom_line_cache

Overview:
- Parametrised, direct-mapped, read-only cache between a CPU program-ROM read port and the SDRAM ROM channel.
- Successor to the single-word 68k program cache, with three additions:
  - configurable address, data and index widths;
  - multi-word line fill, with one SDRAM burst per miss;
  - flush input that invalidates every line without a reset.
- Sits between the CPU bus adaptor and the SDRAM controller ROM port.

Parameters:
- ADDR_W, 23, word-address width of cache_addr and rom_addr.
- DATA_W, 16, data word width.
- SET_W, 8, index bits; number of lines = 2^SET_W.
- LINE_W, 2, word-offset bits; words per line = 2^LINE_W. LINE_W = 0 is legal (single-word lines).
- Tag width = ADDR_W - SET_W - LINE_W; it must be ≥ 1.

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- flush, input, 1, single-cycle pulse; invalidates all lines.
- cache_req, input, 1, read request; level, held until cache_valid is seen.
- cache_addr, input, ADDR_W, word address; stable while cache_req is high.
- cache_valid, output, 1, data ready; stays high while cache_req stays high after completion.
- cache_data, output, DATA_W, read data; valid while cache_valid is high.
- rom_req, output, 1, SDRAM burst request; level.
- rom_addr, output, ADDR_W, line-aligned burst start address (low LINE_W bits = 0).
- rom_data, input, DATA_W, burst beat data.
- rom_valid, input, 1, one pulse per beat; beats arrive in ascending word order.

Behaviour:
- Reset (synchronous, active-high): takes effect on the next clk edge.
  - All valid bits cleared; state = IDLE.
  - cache_valid = 0, rom_req = 0, rom_addr = 0, cache_data = 0, beat counter = 0.
  - Reset mid-fill abandons the burst: rom_req is low on the cycle after reset. The SDRAM side tolerates the abandoned burst.
- Address split: tag = cache_addr[ADDR_W-1 : SET_W+LINE_W]; set = cache_addr[SET_W+LINE_W-1 : LINE_W]; offset = cache_addr[LINE_W-1 : 0].
- Storage:
  - Tag RAM and data RAM are synchronous-read block RAMs.
  - Data RAM depth is 2^(SET_W+LINE_W).
  - Valid bits are held in a flop vector so they can be cleared in one cycle.
- States:
  - IDLE: waits for cache_req = 1, then goes to LOOKUP. RAM addresses are driven from cache_addr.
  - LOOKUP (1 cycle):
    - Hit (valid[set] && tag match) -> HOLD, with cache_valid = 1 and cache_data = RAM word.
    - Miss -> FILL: rom_req = 1, rom_addr = {tag, set, LINE_W'b0}, beat counter = 0.
  - FILL: on each rom_valid:
    - write rom_data into the data RAM at {set, counter};
    - if counter == offset, capture rom_data into the output register;
    - increment the counter.
  - FILL, last beat (counter == 2^LINE_W - 1):
    - rom_req drops on that edge;
    - tag is written; valid[set] = 1 unless a flush arrived during the fill;
    - next state is HOLD if cache_req is still high, else IDLE.
  - HOLD: cache_valid = 1 and cache_data is stable. When cache_req falls, cache_valid = 0 on the next cycle and the state returns to IDLE.
- Latency:
  - Hit: cache_valid is high 2 cycles after cache_req rises.
  - Miss: cache_valid is high 1 cycle after the last beat's rom_valid.
- Handshake rules:
  - The requester drops cache_req for ≥ 1 cycle between requests.
  - cache_addr changes while cache_req is high are undefined usage; they are not checked.
- cache_req falling mid-fill: the burst always completes and the line is installed. cache_valid is never asserted for the abandoned request.
- Flush:
  - In IDLE or HOLD: all valid bits are cleared on the next edge.
  - In LOOKUP: the lookup result is still used; bits are cleared after.
  - In FILL: the line being filled is not marked valid. The captured word is still returned to the requester.
  - flush coincident with reset: reset wins (same outcome).
- rom_valid outside FILL is ignored.
- Beat counter width is LINE_W bits. The counter wraps to 0 on the last beat.

Optional Feature:
- Macro ROM_LINE_CACHE_STATS_EN.
- When defined, adds two output ports:
  - hit_count, 32 bits: increments once per LOOKUP hit.
  - miss_count, 32 bits: increments once per FILL entry.
- Both counters are cleared by reset, not by flush, and saturate at 0xFFFFFFFF.
- When undefined, neither port nor any counter logic exists. Core behaviour is identical either way.

Test Plan:
- Cold miss: after reset, read 0x000105. Expect:
  - rom_req = 1, rom_addr = 0x000104;
  - 4 beats 0xA000..0xA003;
  - cache_valid with data 0xA001 one cycle after the 4th beat.
- Line hit: after the cold miss, read 0x000104, 0x000106 and 0x000107. Each gives cache_valid 2 cycles after cache_req with data 0xA000, 0xA002 and 0xA003; rom_req stays 0.
- Conflict eviction: read 0x000104 (filled), then 0x000504 (same set, different tag) -> miss with rom_addr 0x000504. Re-reading 0x000104 -> miss again.
- Flush during fill: pulse flush on the 2nd beat of a miss at 0x000200. Data is returned normally; a re-read of 0x000200 misses. With ROM_LINE_CACHE_STATS_EN, miss_count = 2 and hit_count = 0.
- Abandoned request: drop cache_req after the 1st beat. All 4 beats are consumed, cache_valid stays 0, and a later read of the same line hits.
- Reset mid-fill: assert reset after the 2nd beat. rom_req = 0 on the next cycle; re-read of the line misses with a full 4-beat burst.
